// File: rtl/inmem_if.sv
// Fetch/load bus of the instruction memory: combinational read port plus one word-write port.
// The memory drives only instruction; fetch stage or loader drives everything else.
interface inmem_if;
  logic [31:0] Address;
  logic [31:0] instruction;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (
    output Address,
    output we,
    output waddr,
    output wdata,
    input  instruction
  );

  modport slave (
    input  Address,
    input  we,
    input  waddr,
    input  wdata,
    output instruction
  );
endinterface

// File: rtl/inmem.sv
// RV32I instruction memory: zero-latency combinational read, one-cycle synchronous word write.
// No backpressure; a synchronous reset reloads the built-in default program.
module inmem #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic   clk,
  input  logic   rst,
  inmem_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef logic [DEPTH-1:0][31:0] image_t;

  function automatic image_t default_image();
    image_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = NOP_WORD;
    end
    img[0] = 32'h00500093;
    img[1] = 32'h00A00113;
    img[2] = 32'h002081B3;
    img[3] = 32'h40110233;
    img[4] = 32'h0020F2B3;
    img[5] = 32'h0020E333;
    img[6] = 32'h00302023;
    img[7] = 32'h00002383;
    img[8] = 32'h00718463;
    return img;
  endfunction

  // Declaration initialiser gives the default program at power-up without a reset.
  image_t r_mem = default_image();

  logic          w_rd_ok;
  logic [AW-1:0] w_rd_idx;
  logic          w_wr_ok;
  logic [AW-1:0] w_wr_idx;

  // Full-width compares so high address bits never alias back into the array.
  assign w_rd_ok  = (bus.Address < SPAN);
  assign w_rd_idx = bus.Address[AW+1:2];
  assign w_wr_ok  = (bus.waddr < SPAN);
  assign w_wr_idx = bus.waddr[AW+1:2];

  assign bus.instruction = w_rd_ok ? r_mem[w_rd_idx] : NOP_WORD;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= default_image();
    end else if (bus.we && w_wr_ok) begin
      r_mem[w_wr_idx] <= bus.wdata;
    end
  end
endmodule

// File: tb/tb_inmem.sv
// Scoreboarded bench for inmem: expected words are queued as addresses are driven, then popped and checked.
module tb_inmem;
  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b0;

  inmem_if bus ();

  inmem #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];

  task automatic load_default();
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    model[0] = 32'h00500093;
    model[1] = 32'h00A00113;
    model[2] = 32'h002081B3;
    model[3] = 32'h40110233;
    model[4] = 32'h0020F2B3;
    model[5] = 32'h0020E333;
    model[6] = 32'h00302023;
    model[7] = 32'h00002383;
    model[8] = 32'h00718463;
  endtask

  function automatic logic [31:0] expect_at(input logic [31:0] a);
    logic [5:0] idx;
    idx = a[7:2];
    if (a >= 32'(DEPTH * 4)) return NOP;
    return model[idx];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    logic [5:0] idx;
    idx = a[7:2];
    if (a < 32'(DEPTH * 4)) model[idx] = d;
  endtask

  task automatic test_powerup();
    logic [31:0] e;
    bus.Address = 32'h0;
    exp_q.push_back(32'h00500093);
    #1;
    e = exp_q.pop_front();
    total++;
    if (bus.instruction !== e) begin
      bad++;
      $display("FAIL powerup addr=00000000 got=%08h want=%08h", bus.instruction, e);
    end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load_default();
    bus.Address = 32'h8;
    exp_q.push_back(32'h002081B3);
    #1;
    e = exp_q.pop_front();
    total++;
    if (bus.instruction !== e) begin
      bad++;
      $display("FAIL reset addr=00000008 got=%08h want=%08h", bus.instruction, e);
    end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] e;
    for (logic [31:0] a = 32'h0; a <= 32'h74; a += 4) begin
      bus.Address = a;
      exp_q.push_back(expect_at(a));
      #10;
      e = exp_q.pop_front();
      total++;
      if (bus.instruction !== e) begin
        bad++;
        $display("FAIL seq_fetch addr=%08h got=%08h want=%08h", a, bus.instruction, e);
      end
    end
  endtask

  task automatic test_boundary();
    logic [31:0] addrs [5];
    logic [31:0] e;
    addrs = '{32'hFC, 32'h100, 32'hFFFFFFFC, 32'h80000000, 32'h104};
    foreach (addrs[i]) begin
      bus.Address = addrs[i];
      exp_q.push_back(NOP);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.instruction !== e) begin
        bad++;
        $display("FAIL boundary addr=%08h got=%08h want=%08h", addrs[i], bus.instruction, e);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] e;
    for (logic [31:0] a = 32'h9; a <= 32'hB; a++) begin
      bus.Address = a;
      exp_q.push_back(32'h002081B3);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.instruction !== e) begin
        bad++;
        $display("FAIL misalign addr=%08h got=%08h want=%08h", a, bus.instruction, e);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    @(negedge clk);
    bus.Address = 32'h24;
    bus.we      = 1'b1;
    bus.waddr   = 32'h24;
    bus.wdata   = 32'hDEADBEEF;
    exp_q.push_back(NOP);
    #1;
    e = exp_q.pop_front();
    total++;
    if (bus.instruction !== e) begin
      bad++;
      $display("FAIL write_before_edge got=%08h want=%08h", bus.instruction, e);
    end
    @(posedge clk);
    model_write(32'h24, 32'hDEADBEEF);
    #1;
    bus.we = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    e = exp_q.pop_front();
    total++;
    if (bus.instruction !== e) begin
      bad++;
      $display("FAIL write_after_edge got=%08h want=%08h", bus.instruction, e);
    end
    // Misaligned write lands on the containing word.
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 32'h2B; bus.wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.we = 1'b0;
    model_write(32'h2B, 32'hCAFEF00D);
    bus.Address = 32'h28;
    exp_q.push_back(expect_at(32'h28));
    #1;
    e = exp_q.pop_front();
    total++;
    if (bus.instruction !== e) begin
      bad++;
      $display("FAIL write_misalign got=%08h want=%08h", bus.instruction, e);
    end
    // Out-of-range write must not alias onto any stored word.
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 32'h100; bus.wdata = 32'h55555555;
    @(negedge clk);
    bus.we = 1'b0;
    for (logic [31:0] a = 32'h0; a <= 32'h100; a += 4) begin
      bus.Address = a;
      exp_q.push_back(expect_at(a));
      #1;
      e = exp_q.pop_front();
      if (a == 32'h0 || a == 32'h24 || a == 32'h100 || e !== bus.instruction) begin
        total++;
        if (bus.instruction !== e) begin
          bad++;
          $display("FAIL oob_write addr=%08h got=%08h want=%08h", a, bus.instruction, e);
        end
      end
    end
  endtask

  task automatic test_reset_restore();
    logic [31:0] chk [3];
    logic [31:0] e;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load_default();
    chk = '{32'h24, 32'h0, 32'h28};
    foreach (chk[i]) begin
      bus.Address = chk[i];
      exp_q.push_back(expect_at(chk[i]));
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.instruction !== e) begin
        bad++;
        $display("FAIL reset_restore addr=%08h got=%08h want=%08h", chk[i], bus.instruction, e);
      end
    end
    // Reset wins over a simultaneous write.
    @(negedge clk);
    rst = 1'b1;
    bus.we = 1'b1; bus.waddr = 32'h0; bus.wdata = 32'h12345678;
    @(negedge clk);
    rst = 1'b0;
    bus.we = 1'b0;
    bus.Address = 32'h0;
    exp_q.push_back(32'h00500093);
    #1;
    e = exp_q.pop_front();
    total++;
    if (bus.instruction !== e) begin
      bad++;
      $display("FAIL reset_priority got=%08h want=%08h", bus.instruction, e);
    end
  endtask

  initial begin
    bus.Address = 32'h0;
    bus.we      = 1'b0;
    bus.waddr   = 32'h0;
    bus.wdata   = 32'h0;
    load_default();
    test_powerup();
    test_reset();
    test_seq_fetch();
    test_boundary();
    test_misalign();
    test_write_read();
    test_reset_restore();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
